// File: rtl/heston_pkg.sv
// heston_pkg: shared Q8.24 types, constants, FSM state encoding and accumulator helpers
package heston_pkg;
  typedef logic signed [31:0] q8_24_t;
  localparam int FRAC_BITS = 24;
  localparam q8_24_t Q_ONE = 32'h0100_0000;
  typedef enum logic [2:0] {ST_IDLE, ST_ACCUM, ST_DISC, ST_WAIT, ST_DONE} state_t;
  // Signed overflow: both operands share a sign that the result does not.
  function automatic logic add_ovf(input q8_24_t a, input q8_24_t b);
    q8_24_t s;
    s = a + b;
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction
  function automatic q8_24_t sat_add(input q8_24_t a, input q8_24_t b);
    return add_ovf(a, b) ? (a[31] ? q8_24_t'(32'h8000_0000) : q8_24_t'(32'h7FFF_FFFF)) : a + b;
  endfunction
endpackage

// File: rtl/mc_price_controller.sv
// mc_price_controller: accumulates N_PATHS Monte-Carlo payoffs, hands the sum to an
// external discount_engine and captures the discounted price.
// Ports: clk/rst (sync, active-high); start pulse with r/T latched on accept;
// payoff_valid/payoff_ready/payoff stream; de_en/de_sum/de_count/de_r/de_T to the
// engine, de_price back; price/price_valid result; busy while a run is in progress.
// Optional build macro ACC_SAT_EN: saturating accumulator plus sticky sat_flag output.
module mc_price_controller
  import heston_pkg::*;
#(
  parameter int N_PATHS    = 100,
  parameter int DE_LATENCY = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  q8_24_t r,
  input  q8_24_t T,
  input  logic   payoff_valid,
  output logic   payoff_ready,
  input  q8_24_t payoff,
  output logic   de_en,
  output q8_24_t de_sum,
  output q8_24_t de_count,
  output q8_24_t de_r,
  output q8_24_t de_T,
  input  q8_24_t de_price,
  output q8_24_t price,
  output logic   price_valid,
`ifdef ACC_SAT_EN
  output logic   sat_flag,
`endif
  output logic   busy
);
  localparam q8_24_t COUNT_Q = q8_24_t'(N_PATHS << FRAC_BITS);
  state_t state_q, state_d;
  q8_24_t sum_q, sum_d, r_q, r_d, t_q, t_d, count_q, count_d, price_q, price_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] wcnt_q, wcnt_d;
`ifdef ACC_SAT_EN
  logic sat_q, sat_d;
  assign sat_flag = sat_q;
`endif
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    r_d     = r_q;
    t_d     = t_q;
    count_d = count_q;
    price_d = price_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
`ifdef ACC_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        r_d     = r;
        t_d     = T;
        sum_d   = '0;
        cnt_d   = '0;
        price_d = '0;
`ifdef ACC_SAT_EN
        sat_d   = 1'b0;
`endif
        state_d = ST_ACCUM;
      end
      ST_ACCUM: if (payoff_valid) begin
`ifdef ACC_SAT_EN
        sum_d = sat_add(sum_q, payoff);
        sat_d = sat_q | add_ovf(sum_q, payoff);
`else
        sum_d = sum_q + payoff;
`endif
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(N_PATHS - 1)) begin
          count_d = COUNT_Q;
          state_d = ST_DISC;
        end
      end
      ST_DISC: begin
        wcnt_d  = 16'(DE_LATENCY);
        state_d = ST_WAIT;
      end
      // de_price becomes valid DE_LATENCY cycles after de_en; the last WAIT cycle is that one.
      ST_WAIT: begin
        wcnt_d = wcnt_q - 16'd1;
        if (wcnt_q == 16'd1) begin
          price_d = de_price;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      r_q     <= '0;
      t_q     <= '0;
      count_q <= '0;
      price_q <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
`ifdef ACC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      r_q     <= r_d;
      t_q     <= t_d;
      count_q <= count_d;
      price_q <= price_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
`ifdef ACC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end
  // sum, r and T only change on an accepted start or in ACCUM, so they are stable DISC..DONE.
  assign payoff_ready = state_q == ST_ACCUM;
  assign de_en        = state_q == ST_DISC;
  assign price_valid  = state_q == ST_DONE;
  assign busy         = state_q != ST_IDLE;
  assign de_sum       = sum_q;
  assign de_count     = count_q;
  assign de_r         = r_q;
  assign de_T         = t_q;
  assign price        = price_q;
endmodule

// File: tb/tb_mc_price_controller.sv
// tb_mc_price_controller: directed self-checking bench with a 3-cycle model discount engine
module tb_mc_price_controller;
  logic clk = 0, rst = 1, start = 0, payoff_valid = 0;
  logic [31:0] r = 0, t_in = 0, payoff = 0;
  logic payoff_ready, de_en, price_valid, busy;
  logic [31:0] de_sum, de_count, de_r, de_T, de_price, price;
`ifdef ACC_SAT_EN
  logic sat_flag;
`endif
  int checks = 0, errors = 0, cyc = 0, lat = 0;
  logic [31:0] pay[4];
  logic [31:0] ds, dc, dr, dt, pr, eng_last = 0, pipe0 = 0, pipe1 = 0, pipe2 = 0;
  int en_n;
  mc_price_controller #(.N_PATHS(4), .DE_LATENCY(3)) dut (
    .clk(clk), .rst(rst), .start(start), .r(r), .T(t_in),
    .payoff_valid(payoff_valid), .payoff_ready(payoff_ready), .payoff(payoff),
    .de_en(de_en), .de_sum(de_sum), .de_count(de_count), .de_r(de_r), .de_T(de_T),
    .de_price(de_price), .price(price), .price_valid(price_valid),
`ifdef ACC_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] eng_f(input logic [31:0] s, c, rr, tt);
    real sv, cv, rv, tv;
    if (c == 0) return 32'h0;
    sv = $itor($signed(s)) / 16777216.0;
    cv = $itor($signed(c)) / 16777216.0;
    rv = $itor($signed(rr)) / 16777216.0;
    tv = $itor($signed(tt)) / 16777216.0;
    return 32'($rtoi(sv / cv * $exp(-rv * tv) * 16777216.0));
  endfunction
  // Model engine: result appears exactly 3 cycles after de_en, zero otherwise.
  always @(posedge clk) begin
    pipe0 <= de_en ? eng_f(de_sum, de_count, de_r, de_T) : 32'h0;
    pipe1 <= pipe0;
    pipe2 <= pipe1;
    if (de_en) eng_last <= eng_f(de_sum, de_count, de_r, de_T);
  end
  assign de_price = pipe2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [31:0] rv, input logic [31:0] tv, input bit noisy);
    int c0, n, g;
    en_n = 0;
    if (noisy) begin
      payoff_valid = 1;
      payoff = 32'h7000_0000;
      @(negedge clk);
      chk("idle_ready", {31'b0, payoff_ready}, 0);
    end
    start = 1; r = rv; t_in = tv; c0 = cyc;
    @(negedge clk);
    start = 0; n = 0; g = 0;
    while (n < 4 && g < 40) begin
      start = noisy && g == 1;
      payoff_valid = 1;
      payoff = pay[n];
      if (payoff_ready) n++;
      @(negedge clk);
      g++;
    end
    start = 0;
    if (noisy) payoff = 32'h7000_0000; else payoff_valid = 0;
    g = 0;
    while (!price_valid && g < 40) begin
      if (de_en) begin
        en_n++;
        ds = de_sum; dc = de_count; dr = de_r; dt = de_T;
      end
      if (noisy && busy) chk("busy_ready", {31'b0, payoff_ready}, 0);
      @(negedge clk);
      g++;
    end
    chk("pv_seen", {31'b0, price_valid}, 1);
    chk("de_sum_stable", de_sum, ds);
    lat = cyc - c0 + 1;
    pr = price;
    chk("de_en_once", en_n, 1);
    @(negedge clk);
    chk("pv_one_cycle", {31'b0, price_valid}, 0);
    chk("busy_after", {31'b0, busy}, 0);
    chk("price_hold", price, pr);
    payoff_valid = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, payoff_ready}, 0);
    chk("rst_de_en", {31'b0, de_en}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_pv", {31'b0, price_valid}, 0);
    chk("rst_price", price, 0);
    chk("rst_de_sum", de_sum, 0);
    chk("rst_de_count", de_count, 0);
    chk("rst_de_rt", de_r | de_T, 0);
    rst = 0;
    // 1.0..4.0, r=0, T=1.0 -> average 2.5
    pay = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000};
    run(32'h0, 32'h0100_0000, 0);
    chk("r1_de_sum", ds, 32'h0A00_0000);
    chk("r1_de_count", dc, 32'h0400_0000);
    chk("r1_de_r", dr, 32'h0);
    chk("r1_de_T", dt, 32'h0100_0000);
    chk("r1_price", pr, 32'h0280_0000);
    chk("r1_latency", lat, 1 + 4 + 1 + 3 + 1);
    // 10.0 each, r=0.05, T=1.0, noisy valid/start -> ~9.5123
    pay = '{32'h0A00_0000, 32'h0A00_0000, 32'h0A00_0000, 32'h0A00_0000};
    run(32'h000C_CCCD, 32'h0100_0000, 1);
    chk("r2_de_sum", ds, 32'h2800_0000);
    chk("r2_de_r", dr, 32'h000C_CCCD);
    chk("r2_model", pr, eng_last);
    chk("r2_tol", {31'b0, ($signed(pr) - 32'sd159589818 < 32'sd4096) && (32'sd159589818 - $signed(pr) < 32'sd4096)}, 1);
    chk("r2_latency", lat, 10);
    // reset after 3 of 4 payoffs
    start = 1; r = 32'h0; t_in = 32'h0100_0000;
    @(negedge clk);
    start = 0; payoff_valid = 1; payoff = 32'h0100_0000;
    repeat (3) @(negedge clk);
    rst = 1; payoff_valid = 0;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_de_en", {31'b0, de_en}, 0);
    chk("mid_rst_ready", {31'b0, payoff_ready}, 0);
    chk("mid_rst_sum", de_sum, 0);
    chk("mid_rst_price", price, 0);
    rst = 0;
    pay = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000};
    run(32'h0, 32'h0100_0000, 0);
    chk("r3_price", pr, 32'h0280_0000);
    chk("r3_de_sum", ds, 32'h0A00_0000);
    // 100.0 x4 overflows the Q8.24 range
    pay = '{32'h6400_0000, 32'h6400_0000, 32'h6400_0000, 32'h6400_0000};
    run(32'h0, 32'h0100_0000, 0);
`ifdef ACC_SAT_EN
    chk("ovf_sat_sum", ds, 32'h7FFF_FFFF);
    chk("ovf_sat_flag", {31'b0, sat_flag}, 1);
`else
    chk("ovf_wrap_sum", ds, 32'h9000_0000);
`endif
    pay = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
    run(32'h0, 32'h0100_0000, 0);
    chk("r5_price", pr, 32'h0100_0000);
`ifdef ACC_SAT_EN
    chk("sat_cleared", {31'b0, sat_flag}, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_price_controller.md
MC_PRICE_CONTROLLER -- requirements
Module: mc_price_controller

Interface
REQ-001 SHALL have parameter N_PATHS, default 100, number of path payoffs per pricing run (legal 1..127, the Q8.24 integer range).
REQ-002 SHALL have parameter DE_LATENCY, default 1, cycles from de_en high until de_price is valid.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins a pricing run.
REQ-006 r, T  input  32 each  signed Q8.24 rate and maturity, latched on an accepted start.
REQ-007 payoff_valid / payoff_ready  input / output  1 each  payoff stream handshake; a transfer occurs when both are high.
REQ-008 payoff  input  32  signed Q8.24 path payoff.
REQ-009 de_en  output  1  enable pulse to discount_engine.
REQ-010 de_sum, de_count, de_r, de_T  output  32 each  signed Q8.24 operands to discount_engine.
REQ-011 de_price  input  32  signed Q8.24 discounted price returned by discount_engine.
REQ-012 price  output  32  captured discounted price, valid while price_valid is high.
REQ-013 price_valid, busy  output  1 each  result-valid flag and run-in-progress flag.

Function
REQ-014 SHALL implement the FSM IDLE -> ACCUM -> DISC -> WAIT -> DONE -> IDLE.
REQ-015 IDLE: start=1 latches r and T, clears sum and path counter, clears price_valid, and moves to ACCUM; start in any other state SHALL be ignored.
REQ-016 ACCUM: payoff_ready=1; each transfer adds payoff to sum and increments the path counter.
REQ-017 ACCUM: the transfer that brings the counter to N_PATHS moves the FSM to DISC, and payoff_ready SHALL be 0 from the next cycle.
REQ-018 payoff_ready SHALL be 0 in every state except ACCUM; payoff_valid outside ACCUM SHALL be ignored and SHALL NOT alter sum.
REQ-019 DISC: de_en=1 for exactly one cycle with de_sum=sum, de_count=N_PATHS<<24, de_r=r_latched, de_T=T_latched; next state is WAIT.
REQ-020 de_sum/de_count/de_r/de_T SHALL stay stable from DISC until DONE.
REQ-021 WAIT: a down-counter loaded with DE_LATENCY; de_price is captured into price on the cycle the counter expires; next state is DONE.
REQ-022 DONE: price_valid=1 for one cycle, then IDLE; price holds its value until the next accepted start or rst.
REQ-023 busy=1 in every state except IDLE.
REQ-024 Total latency: start to price_valid = 1 + (cycles to accept N_PATHS payoffs) + 1 + DE_LATENCY + 1 cycles; with back-to-back payoffs the accept phase is N_PATHS cycles.
REQ-025 Without saturation (see Configuration), sum SHALL wrap as 32-bit two's complement.
REQ-026 N_PATHS=1: a single transfer SHALL move the FSM ACCUM->DISC.
REQ-027 start and a payoff transfer in the same cycle while in IDLE: start is accepted, the payoff is not.

Reset
REQ-028 rst=1 at any clock edge, including mid-run, SHALL force IDLE and zero sum, counter, price, latched r/T and all de_* outputs, and drive de_en, payoff_ready, price_valid and busy to 0.
REQ-029 The first start SHALL be accepted on the cycle after rst deasserts.

Configuration
REQ-030 Macro ACC_SAT_EN: when defined, the accumulator SHALL saturate to 32'h7FFFFFFF on positive overflow and to 32'h80000000 on negative overflow, and a sticky output sat_flag (1 bit) SHALL be set for the run, cleared by start and by rst.
REQ-031 Without ACC_SAT_EN, the accumulator wraps and the sat_flag port SHALL NOT exist.

Structure
REQ-032 Shared package heston_pkg SHALL hold the q8_24_t typedef (signed 32-bit), FRAC_BITS=24, Q_ONE=32'h01000000, and the FSM state enum.
REQ-033 No sub-module inside; discount_engine SHALL be instantiated beside this block at the next level up, with de_en/de_price wired to its en/price_out.

Verification
REQ-034 N_PATHS=4; payoffs 1.0, 2.0, 3.0, 4.0 (0x01000000..0x04000000); r=0; T=1.0 -> de_sum=0x0A000000, de_count=0x04000000, price ~= 2.5 (0x02800000) within the discount_engine tolerance.
REQ-035 r=0.05, T=1.0, N_PATHS=10, each payoff 10.0 -> price ~= 9.5123 (exp(-0.05)*10), price_valid high for one cycle, busy low the cycle after.
REQ-036 payoff_valid held high in IDLE and in DISC/WAIT -> payoff_ready=0 and sum unchanged; start pulse during ACCUM -> ignored, count unaffected.
REQ-037 rst asserted after 3 of 10 payoffs -> next cycle IDLE, busy=0, de_en=0; a new run after reset produces a correct price.
REQ-038 ACC_SAT_EN defined; N_PATHS=3; payoffs 100.0 each -> sum=0x7FFFFFFF and sat_flag=1; without the macro -> sum wraps to the two's-complement value.
REQ-039 DE_LATENCY=3 with a model engine delaying price by 3 cycles -> the captured price equals the model output, and the start-to-price_valid latency matches REQ-024.
